ro_window_counter: RTL and testbench

Gated edge counter that converts the free-running ring-oscillator signal into a 16-bit frequency sample. It synchronises the oscillator output into `clk`, counts rising edges over a programmable window of reference-clock cycles, and presents each result on a valid/ready interface. It sits directly upstream of the UART result transmitter, which drives `tx` and the parallel `counter` pins.

---
 rtl/ro_window_counter_if.sv | 23 ++
 rtl/ro_window_counter.sv | 136 +++++++++++++
 tb/tb_ro_window_counter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_window_counter_if.sv
// Result handshake bundle for ro_window_counter: latched count, overflow flag, valid/ready.
interface ro_window_counter_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ready;
  logic             overflow;

  modport master (
    output count_out,
    output count_valid,
    output overflow,
    input  count_ready
  );

  modport slave (
    input  count_out,
    input  count_valid,
    input  overflow,
    output count_ready
  );
endinterface

// File: rtl/ro_window_counter.sv
// Gated ring-oscillator edge counter producing one result per window on a valid/ready port.
// Optional feature: define ROCNT_SATURATE_EN to saturate the edge counter instead of wrapping.
module ro_window_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ro_in,
  input  logic [WIN_W-1:0]    window_len,
  input  logic                start,
  input  logic                continuous,
  ro_window_counter_if.master res,
  output logic                overrun,
  output logic                busy
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [WIN_W-1:0]       win_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic                   ovf_q;
  logic [CNT_W-1:0]       count_out_q;
  logic                   count_valid_q;
  logic                   overflow_q;
  logic                   overrun_q;
  logic                   busy_q;

  logic                   edge_det;
  logic [CNT_W-1:0]       edge_cnt_d;
  logic                   ovf_d;
  logic                   win_end;
  logic                   res_load;

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign win_end  = (state_q == MEASURE) && (win_cnt_q == WIN_W'(1));
  assign res_load = win_end && (!count_valid_q || res.count_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Count including the edge seen this cycle, so the last window cycle is not lost.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (edge_det) begin
      if (edge_cnt_q == '1) begin
        ovf_d = 1'b1;
`ifdef ROCNT_SATURATE_EN
        edge_cnt_d = edge_cnt_q;
`else
        edge_cnt_d = '0;
`endif
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      edge_cnt_q    <= '0;
      ovf_q         <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      overrun_q <= win_end && !res_load;

      if (res_load) begin
        count_out_q   <= edge_cnt_d;
        overflow_q    <= ovf_d;
        count_valid_q <= 1'b1;
      end else if (count_valid_q && res.count_ready) begin
        count_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start && (window_len != '0)) begin
            state_q    <= MEASURE;
            busy_q     <= 1'b1;
            win_cnt_q  <= window_len;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end
        end
        MEASURE: begin
          if (win_cnt_q == WIN_W'(1)) begin
            if (continuous && (window_len != '0)) begin
              win_cnt_q  <= window_len;
              edge_cnt_q <= '0;
              ovf_q      <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            win_cnt_q  <= win_cnt_q - 1'b1;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign res.count_out   = count_out_q;
  assign res.count_valid = count_valid_q;
  assign res.overflow    = overflow_q;
  assign overrun         = overrun_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_ro_window_counter.sv
// Bench for ro_window_counter: table of single windows, hand sequences, random windows vs edge-history model.
module tb_ro_window_counter;

  localparam int S = 2;
`ifdef ROCNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ro_in = 1'b0;
  logic [15:0] window_len = '0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        ready = 1'b1;
  logic        overrun16, busy16, overrun4, busy4;

  int          ro_per = 0;
  int          ro_ph = 0;
  bit          ro_rand = 1'b0;
  bit          rov [0:16383];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  ro_window_counter_if #(.CNT_W(16)) if16 ();
  ro_window_counter_if #(.CNT_W(4))  if4 ();
  assign if16.count_ready = ready;
  assign if4.count_ready  = ready;

  ro_window_counter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(S)) dut16 (
    .clk(clk), .rst(rst), .ro_in(ro_in), .window_len(window_len), .start(start),
    .continuous(continuous), .res(if16), .overrun(overrun16), .busy(busy16)
  );

  ro_window_counter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(S)) dut4 (
    .clk(clk), .rst(rst), .ro_in(ro_in), .window_len(window_len), .start(start),
    .continuous(continuous), .res(if4), .overrun(overrun4), .busy(busy4)
  );

  always #5 clk = ~clk;

  // Oscillator stand-in: periodic (one rise per ro_per cycles) or random bits.
  always @(posedge clk) begin
    #2;
    if (ro_per != 0) begin
      ro_ph = (ro_ph + 1 >= ro_per) ? 0 : ro_ph + 1;
      ro_in = (ro_ph < ro_per / 2);
    end else begin
      ro_in = ro_rand ? 1'($urandom % 2) : 1'b0;
    end
  end

  always @(posedge clk) begin
    if (cyc < 16384) rov[cyc] = ro_in;
    cyc = cyc + 1;
  end

  // Rising edges of the sampled oscillator whose detection lands in the n cycles ending at posedge x.
  function automatic int model_count(input int x, input int n);
    int total = 0;
    for (int c = x - n + 1 - S; c <= x - S; c++)
      if (c >= 1 && c < 16384 && rov[c] && !rov[c-1]) total++;
    return total;
  endfunction

  function automatic int exp4_count(input int n);
    if (n > 15) return SAT ? 15 : n % 16;
    return n;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic start_meas(input int len);
    @(negedge clk);
    window_len = 16'(len);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (if16.count_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int len;
    int per;
    int exp_cnt;
  } vec_t;

  initial begin
    vec_t vecs [8];
    bit   ok;
    int   bc, exp, prev;
    bit   flag;

    vecs[0] = '{100, 4, 25};
    vecs[1] = '{40,  2, 20};
    vecs[2] = '{16,  4, 4};
    vecs[3] = '{30,  6, 5};
    vecs[4] = '{2,   2, 1};
    vecs[5] = '{20, 10, 2};
    vecs[6] = '{9,   3, 3};
    vecs[7] = '{15,  5, 3};

    repeat (3) @(negedge clk);
    check("rst_count_out", int'(if16.count_out), 0);
    check("rst_valid", int'(if16.count_valid), 0);
    check("rst_overflow", int'(if16.overflow), 0);
    check("rst_overrun", int'(overrun16), 0);
    check("rst_busy", int'(busy16), 0);
    rst = 1'b0;

    // Single non-continuous windows with periodic input.
    foreach (vecs[i]) begin
      ro_per = vecs[i].per;
      repeat (20) @(negedge clk);
      start_meas(vecs[i].len);
      bc = 0;
      ok = 1'b0;
      for (int k = 0; k < vecs[i].len + 10; k++) begin
        if (if16.count_valid) begin
          ok = 1'b1;
          break;
        end
        if (busy16) bc++;
        @(negedge clk);
      end
      check($sformatf("tbl%0d_timeout", i), int'(ok), 1);
      check($sformatf("tbl%0d_busy_cycles", i), bc, vecs[i].len);
      check($sformatf("tbl%0d_busy_end", i), int'(busy16), 0);
      check($sformatf("tbl%0d_count", i), int'(if16.count_out), vecs[i].exp_cnt);
      check($sformatf("tbl%0d_ovf", i), int'(if16.overflow), 0);
      check($sformatf("tbl%0d_count4", i), int'(if4.count_out), exp4_count(vecs[i].exp_cnt));
      check($sformatf("tbl%0d_ovf4", i), int'(if4.overflow), int'(vecs[i].exp_cnt > 15));
      @(negedge clk);
      check($sformatf("tbl%0d_valid_drop", i), int'(if16.count_valid), 0);
    end

    // Reset in the middle of a window.
    ro_per = 4;
    repeat (10) @(negedge clk);
    start_meas(100);
    repeat (38) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy16), 0);
    check("midrst_valid", int'(if16.count_valid), 0);
    check("midrst_count", int'(if16.count_out), 0);
    check("midrst_overrun", int'(overrun16), 0);
    rst = 1'b0;
    flag = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (if16.count_valid || busy16) flag = 1'b1;
    end
    check("midrst_no_result", int'(flag), 0);

    // Zero-length window is ignored.
    start_meas(0);
    flag = 1'b0;
    repeat (10) begin
      if (if16.count_valid || busy16) flag = 1'b1;
      @(negedge clk);
    end
    check("zero_win_ignored", int'(flag), 0);

    // Continuous windows under backpressure.
    ro_per = 2;
    ready = 1'b0;
    continuous = 1'b1;
    repeat (10) @(negedge clk);
    start_meas(8);
    wait_valid(20, ok);
    check("cont_first_timeout", int'(ok), 1);
    check("cont_first_count", int'(if16.count_out), 4);
    flag = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!if16.count_valid || if16.count_out != 16'd4) flag = 1'b1;
      if (k < 8 && overrun16) flag = 1'b1;
    end
    check("cont_held_stable", int'(flag), 0);
    check("cont_overrun_2nd_end", int'(overrun16), 1);
    ready = 1'b1;
    @(negedge clk);
    check("cont_consumed", int'(if16.count_valid), 0);
    wait_valid(20, ok);
    check("cont_next_timeout", int'(ok), 1);
    check("cont_next_count", int'(if16.count_out), 4);
    check("cont_next_overrun", int'(overrun16), 0);

    // Accept and load on the same window-end cycle; input stopped so the count changes.
    ready = 1'b0;
    ro_per = 0;
    ro_rand = 1'b0;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    ready = 1'b1;
    prev = int'(if16.count_out);
    @(negedge clk);
    exp = model_count(cyc - 1, 8);
    check("simul_valid", int'(if16.count_valid), 1);
    check("simul_overrun", int'(overrun16), 0);
    check("simul_count", int'(if16.count_out), exp);
    check("simul_changed", int'(int'(if16.count_out) != prev), 1);
    @(negedge clk);
    check("simul_drop", int'(if16.count_valid), 0);
    continuous = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy16) begin
        flag = 1'b1;
        break;
      end
    end
    check("cont_stop", int'(flag), 1);

    // Random windows against the edge-history model.
    ro_rand = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      int len;
      len = $urandom_range(1, 40);
      repeat ($urandom_range(3, 8)) @(negedge clk);
      start_meas(len);
      wait_valid(len + 10, ok);
      check($sformatf("rnd%0d_timeout", i), int'(ok), 1);
      exp = model_count(cyc - 1, len);
      check($sformatf("rnd%0d_count", i), int'(if16.count_out), exp);
      check($sformatf("rnd%0d_ovf", i), int'(if16.overflow), 0);
      check($sformatf("rnd%0d_count4", i), int'(if4.count_out), exp4_count(exp));
      check($sformatf("rnd%0d_ovf4", i), int'(if4.overflow), int'(exp > 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
